// File: rtl/mdu.sv
// mdu -- multiply/divide unit with HI/LO result registers.
//
// Multiplies and divides run for a fixed number of cycles (MULT_CYCLES or
// DIV_CYCLES). During that time busy is high and hi/lo hold their previous
// contents. On the last edge hi/lo take the result, busy drops and done
// pulses for one cycle. mthi/mtlo write srcA straight into hi/lo when the
// unit is idle.
//
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high
//   start  : request qualifier; MDUOp/srcA/srcB are sampled when high
//   MDUOp  : 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo,
//            110/111 no-op
//   srcA   : multiplicand / dividend / move source
//   srcB   : multiplier / divisor
//   hi, lo : result registers
//   busy   : multiply/divide in progress
//   done   : one-cycle pulse on the edge the result lands
//
// State table:
//   S_IDLE | accepting requests; mthi/mtlo act immediately
//   S_BUSY | op latched, counter running down to the completion edge

module mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // The counter only ever holds load values up to MAX_CYC-1, so it can
  // never wrap regardless of the parameter choice.
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;   // [1]=divide, [0]=unsigned
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Result datapath, evaluated from the latched operands.
  logic [2*WIDTH-1:0]        a_sx, b_sx, a_zx, b_zx;
  logic [2*WIDTH-1:0]        prod_s, prod_u;
  logic                      div_zero, div_ovf;
  logic [WIDTH-1:0]          div_s_b, div_u_b;
  logic signed [WIDTH-1:0]   quot_s, rem_s;
  logic [WIDTH-1:0]          quot_u, rem_u;

  assign a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign a_zx   = {{WIDTH{1'b0}}, a_q};
  assign b_zx   = {{WIDTH{1'b0}}, b_q};
  // Low 2*WIDTH bits of the sign-extended product equal the signed product.
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  assign div_zero = (b_q == '0);
  assign div_ovf  = (a_q == MOST_NEG) && (b_q == '1);

  // Dividing by 1 in the overflow case gives exactly the required
  // most-negative quotient with zero remainder, and keeps the divider away
  // from the undefined MIN/-1 case. A zero divisor is also replaced; its
  // result is discarded anyway.
  assign div_s_b = (div_zero || div_ovf) ? ONE : b_q;
  assign div_u_b = div_zero ? ONE : b_q;
  assign quot_s  = $signed(a_q) / $signed(div_s_b);
  assign rem_s   = $signed(a_q) % $signed(div_s_b);
  assign quot_u  = a_q / div_u_b;
  assign rem_u   = a_q % div_u_b;

  assign busy = (state == S_BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            case (MDUOp)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state <= S_BUSY;
                op_q  <= MDUOp[1:0];
                a_q   <= srcA;
                b_q   <= srcB;
                cnt   <= MDUOp[1] ? DIV_LOAD : MULT_LOAD;
              end
              OP_MTHI: hi <= srcA;
              OP_MTLO: lo <= srcA;
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            done  <= 1'b1;
            case (op_q)
              2'b00: {hi, lo} <= prod_s;
              2'b01: {hi, lo} <= prod_u;
              2'b10: if (!div_zero) begin
                hi <= rem_s;
                lo <= quot_s;
              end
              default: if (!div_zero) begin
                hi <= rem_u;
                lo <= quot_u;
              end
            endcase
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- directed plus randomized checks of mdu against an arithmetic
// reference model (64-bit integer math on the operands).

module tb_mdu;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   MDUOp = 3'b000;
  logic [W-1:0] srcA = '0;
  logic [W-1:0] srcB = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .MDUOp (MDUOp),
    .srcA  (srcA),
    .srcB  (srcB),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {hi, lo} after the op, given the values before it.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return {h, l};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {h, l};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd4: return {a, l};
      3'd5: return {h, a};
      default: return {h, l};
    endcase
  endfunction

  // Called at a negedge with the unit idle (or in its done cycle). Returns at
  // the negedge following completion (done cycle for mult/div).
  task automatic exec_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit intrude);
    logic [63:0] r;
    int n;
    r = ref_result(op, a, b, m_hi, m_lo);
    MDUOp = op;
    srcA  = a;
    srcB  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    srcA  = $urandom;
    srcB  = $urandom;
    MDUOp = 3'($urandom_range(0, 7));
    if (op <= 3'd3) begin
      n = op[1] ? DC : MC;
      for (int i = 0; i < n; i++) begin
        chk("busy_high", 64'(busy), 64'd1);
        chk("done_low_busy", 64'(done), 64'd0);
        chk("hi_hold", 64'(hi), 64'(m_hi));
        chk("lo_hold", 64'(lo), 64'(m_lo));
        if (intrude) begin
          if (i == 1) begin
            start = 1'b1;
            MDUOp = 3'b010;
            srcA  = $urandom;
            srcB  = $urandom_range(1, 100);
          end else if (i == 2) begin
            MDUOp = 3'b101;
            srcA  = $urandom;
          end else if (i == 3) begin
            start = 1'b0;
          end
        end
        @(negedge clk);
      end
      chk("busy_clear", 64'(busy), 64'd0);
      chk("done_pulse", 64'(done), 64'd1);
    end else begin
      chk("busy_move", 64'(busy), 64'd0);
      chk("done_move", 64'(done), 64'd0);
    end
    m_hi = r[63:32];
    m_lo = r[31:0];
    chk("hi_result", 64'(hi), 64'(m_hi));
    chk("lo_result", 64'(lo), 64'(m_lo));
  endtask

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_done", 64'(done), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_hi", 64'(hi), 64'(m_hi));
      chk("idle_lo", 64'(lo), 64'(m_lo));
    end
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    // Reset held with a request present: it must be ignored.
    reset = 1'b1;
    start = 1'b1;
    MDUOp = 3'b100;
    srcA  = 32'hA5A5A5A5;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // First request taken at the first edge with reset low.
    reset = 1'b0;
    exec_op(3'b100, 32'h12345678, 32'h0, 0);
    chk("mthi_const", 64'(hi), 64'h12345678);
    exec_op(3'b011, 32'd5, 32'd0, 0);
    chk("divu0_hi", 64'(hi), 64'h12345678);
    chk("divu0_lo", 64'(lo), 64'h0);
    idle_chk(1);

    exec_op(3'b000, 32'hFFFFFFFF, 32'h2, 0);
    chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(lo), 64'hFFFFFFFE);
    idle_chk(2);

    exec_op(3'b001, 32'hFFFFFFFF, 32'h2, 0);
    chk("multu_hi", 64'(hi), 64'h00000001);
    chk("multu_lo", 64'(lo), 64'hFFFFFFFE);
    idle_chk(1);

    exec_op(3'b010, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_hi", 64'(hi), 64'hFFFFFFFF);
    chk("div_lo", 64'(lo), 64'hFFFFFFFD);
    // Presented in the done cycle: accepted with no gap.
    exec_op(3'b000, 32'd3, 32'hFFFFFFFB, 0);
    exec_op(3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 0);
    idle_chk(1);

    exec_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("ovf_hi", 64'(hi), 64'h0);
    chk("ovf_lo", 64'(lo), 64'h80000000);
    exec_op(3'b010, 32'd7, 32'd0, 0);
    exec_op(3'b010, 32'd7, 32'hFFFFFFFE, 0);

    // div and mtlo offered while busy are ignored.
    exec_op(3'b000, $urandom, $urandom, 1);
    idle_chk(2);

    exec_op(3'b110, $urandom, $urandom, 0);
    exec_op(3'b111, $urandom, $urandom, 0);
    exec_op(3'b101, $urandom, 32'h0, 0);
    idle_chk(1);

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 16));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      exec_op(rop, ra, rb, 0);
      if ($urandom_range(0, 1) == 1) idle_chk(1);
    end

    // Reset during a divide aborts it with no later result or done.
    exec_op(3'b100, 32'hDEADBEEF, 32'h0, 0);
    exec_op(3'b101, 32'hCAFEF00D, 32'h0, 0);
    MDUOp = 3'b010;
    srcA  = 32'd100;
    srcB  = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    idle_chk(DC + 4);

    exec_op(3'b001, $urandom, $urandom, 0);
    idle_chk(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
